// File: rtl/fifo_drain_seq.sv
// fifo_drain_seq: read-side sequencer for the board FIFO.
// Pops one word at a time, holds it on the LEDs for HOLD_CYCLES cycles,
// counts popped words and flags a pop attempted while the FIFO is empty.
// Optional feature macro: FIFO_DRAIN_BACK_TO_BACK_EN (HOLD exits straight
// to FETCH when more data is waiting, skipping the IDLE cycle).
module fifo_drain_seq #(
  parameter int unsigned DATA_W      = 3,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned HOLD_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic [7:0]        count,
  output logic              error
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] dout_d;
  logic [7:0]        count_d;
  logic              error_d;

  // State and output registers; busy/dout_valid are decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_q     <= '0;
      dout       <= '0;
      count      <= '0;
      error      <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      hold_q     <= hold_d;
      dout       <= dout_d;
      count      <= count_d;
      error      <= error_d;
      dout_valid <= (state_d == HOLD);
      busy       <= (state_d != IDLE);
    end
  end

  // Next-state logic, register next values and the combinational pop strobe
  always_comb begin
    state_d = state;
    hold_d  = hold_q;
    dout_d  = dout;
    count_d = count;
    error_d = error;
    rd      = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) state_d = FETCH;
      end
      FETCH: begin
        rd = !empty;
        if (!empty) begin
          dout_d  = rd_data;
          count_d = count + 8'd1;
          hold_d  = HOLD_LOAD;
          state_d = HOLD;
        end else begin
          // Head word vanished between IDLE and FETCH: record and back off
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
`ifdef FIFO_DRAIN_BACK_TO_BACK_EN
          if (en && !empty) state_d = FETCH;
          else              state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_drain_seq.sv
// Directed testbench for fifo_drain_seq with HOLD_CYCLES=4 and a simple
// FWFT FIFO model (pointer pair over a memory) feeding the read port.
module tb_fifo_drain_seq;

  localparam int unsigned DATA_W      = 3;
  localparam int unsigned HOLD_CYCLES = 4;
  localparam int unsigned HOLD_W      = 3;
`ifdef FIFO_DRAIN_BACK_TO_BACK_EN
  localparam int unsigned SPACING = HOLD_CYCLES + 1;
`else
  localparam int unsigned SPACING = HOLD_CYCLES + 2;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              empty;
  logic              force_empty;
  logic [DATA_W-1:0] rd_data;
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic [7:0]        count;
  logic              error;

  logic [DATA_W-1:0] mem [0:1023];
  logic [9:0]        rd_ptr = '0;
  logic [9:0]        wr_ptr = '0;
  int                cyc = 0;
  int                n_chk = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  fifo_drain_seq #(
    .DATA_W     (DATA_W),
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .empty     (empty),
    .rd_data   (rd_data),
    .rd        (rd),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .count     (count),
    .error     (error)
  );

  // FWFT FIFO model: head word visible whenever non-empty, pops on rd
  assign empty   = force_empty || (rd_ptr == wr_ptr);
  assign rd_data = mem[rd_ptr];

  // Cycle counter and FIFO read pointer
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd) rd_ptr <= rd_ptr + 10'd1;
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic wait_rd(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      if (rd) begin
        c = cyc;
        break;
      end
      step();
    end
    if (c < 0) chk("wait_rd_timeout", 0, 1);
  endtask

  int c0, c1, c2;
  logic [9:0] saved_ptr;
  bit done;

  initial begin
    reset = 1'b0;
    en = 1'b0;
    force_empty = 1'b0;
    step();
    step();
    chk("rst_rd", rd, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Single word
    push(3'b011);
    en = 1'b1;
    step();
    chk("single_rd", rd, 1);
    chk("single_fetch_valid", dout_valid, 0);
    chk("single_fetch_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_valid", dout_valid, 1);
      chk("single_dout", dout, 3);
      chk("single_rd_low", rd, 0);
    end
    step();
    chk("single_end_valid", dout_valid, 0);
    chk("single_end_busy", busy, 0);
    chk("single_end_dout", dout, 3);
    chk("single_count", count, 1);
    chk("single_pops", rd_ptr, 1);

    // Asynchronous reset in the middle of HOLD
    push(3'b101);
    step();
    chk("rh_rd", rd, 1);
    step();
    chk("rh_dout", dout, 5);
    chk("rh_count", count, 2);
    step();
    #2 reset = 1'b0;
    #1;
    chk("rh_rd0", rd, 0);
    chk("rh_dout0", dout, 0);
    chk("rh_valid0", dout_valid, 0);
    chk("rh_busy0", busy, 0);
    chk("rh_count0", count, 0);
    chk("rh_error0", error, 0);
    step();
    reset = 1'b1;

    // Burst of three words
    en = 1'b0;
    push(3'b011);
    push(3'b010);
    push(3'b001);
    en = 1'b1;
    wait_rd(c0);
    step();
    chk("burst_dout0", dout, 3);
    chk("burst_valid0", dout_valid, 1);
    wait_rd(c1);
    chk("burst_space1", unsigned'(c1 - c0), SPACING);
    step();
    chk("burst_dout1", dout, 2);
    wait_rd(c2);
    chk("burst_space2", unsigned'(c2 - c1), SPACING);
    step();
    chk("burst_dout2", dout, 1);
    for (int i = 0; i < 4; i++) step();
    chk("burst_busy", busy, 0);
    chk("burst_valid_end", dout_valid, 0);
    chk("burst_count", count, 3);
    chk("burst_error", error, 0);
    chk("burst_dout_end", dout, 1);

    // Underflow: empty rises during FETCH
    push(3'b110);
    step();
    chk("uf_fetch_rd", rd, 1);
    saved_ptr = rd_ptr;
    force_empty = 1'b1;
    en = 1'b0;
    #1;
    chk("uf_rd", rd, 0);
    step();
    chk("uf_error", error, 1);
    chk("uf_count", count, 3);
    chk("uf_busy", busy, 0);
    chk("uf_valid", dout_valid, 0);
    chk("uf_dout", dout, 1);
    chk("uf_nopop", rd_ptr, saved_ptr);
    force_empty = 1'b0;
    step();
    step();
    chk("uf_error_sticky", error, 1);
    chk("uf_idle", busy, 0);

    // Enable drop mid-HOLD with two words queued (3'b110 still at head)
    push(3'b101);
    en = 1'b1;
    wait_rd(c0);
    step();
    chk("ed_dout", dout, 6);
    chk("ed_count", count, 4);
    step();
    en = 1'b0;
    chk("ed_valid2", dout_valid, 1);
    step();
    chk("ed_valid3", dout_valid, 1);
    step();
    chk("ed_valid4", dout_valid, 1);
    step();
    chk("ed_end_valid", dout_valid, 0);
    chk("ed_end_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ed_no_rd", rd, 0);
      step();
    end
    en = 1'b1;
    step();
    chk("ed_resume_rd", rd, 1);
    step();
    chk("ed_resume_dout", dout, 5);
    chk("ed_resume_count", count, 5);
    en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ed_resume_idle", busy, 0);

    // Asynchronous reset during FETCH consumes nothing
    push(3'b111);
    en = 1'b1;
    step();
    chk("rf_rd", rd, 1);
    saved_ptr = rd_ptr;
    #2 reset = 1'b0;
    en = 1'b0;
    #1;
    chk("rf_rd0", rd, 0);
    chk("rf_busy0", busy, 0);
    chk("rf_error0", error, 0);
    step();
    reset = 1'b1;
    step();
    chk("rf_nopop", rd_ptr, saved_ptr);

    // Count wrap: 256 pops (leftover 3'b111 plus 255 more)
    for (int i = 1; i < 256; i++) push(3'(i));
    en = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (empty && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("wrap_done", done, 1);
    chk("wrap_count", count, 0);
    chk("wrap_error", error, 0);
    chk("wrap_dout", dout, 7);
    chk("wrap_drained", rd_ptr, wr_ptr);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
